// File: rtl/basic_datapath.sv
// Register/memory datapath for the accumulator CPU: AR, PC, DR, AC, IR, TR, E,
// a shared 16-bit bus, the ALU and a single-port word memory with a program-load port.
module basic_datapath #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [23:0]   reg_mem_ctrl,
    input  logic [2:0]    bus_ctrl,
    output logic [3:0]    instruction,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    output logic [15:0]   ac_out,
    output logic [AW-1:0] pc_out,
    output logic          e_out
);

    localparam int DEPTH = 1 << AW;

    logic ar_ld, ar_inc, ar_clr;
    logic pc_ld, pc_inc, pc_clr;
    logic dr_ld, dr_inc, dr_clr;
    logic ac_ld, ac_inc, ac_clr;
    logic ir_ld;
    logic tr_ld, tr_inc, tr_clr;
    logic mem_rd, mem_wr;
    logic unused_ctrl_bits;

    assign ar_ld  = reg_mem_ctrl[3];
    assign ar_inc = reg_mem_ctrl[4];
    assign ar_clr = reg_mem_ctrl[5];
    assign pc_ld  = reg_mem_ctrl[6];
    assign pc_inc = reg_mem_ctrl[7];
    assign pc_clr = reg_mem_ctrl[8];
    assign dr_ld  = reg_mem_ctrl[9];
    assign dr_inc = reg_mem_ctrl[10];
    assign dr_clr = reg_mem_ctrl[11];
    assign ac_ld  = reg_mem_ctrl[12];
    assign ac_inc = reg_mem_ctrl[13];
    assign ac_clr = reg_mem_ctrl[14];
    assign ir_ld  = reg_mem_ctrl[15];
    assign tr_ld  = reg_mem_ctrl[18];
    assign tr_inc = reg_mem_ctrl[19];
    assign tr_clr = reg_mem_ctrl[20];
    assign mem_rd = reg_mem_ctrl[21];
    assign mem_wr = reg_mem_ctrl[22];
    assign unused_ctrl_bits = ^{reg_mem_ctrl[2:0], reg_mem_ctrl[17:16], reg_mem_ctrl[23]};

    logic [AW-1:0] ar_q, ar_d, pc_q, pc_d;
    logic [15:0]   dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
    logic          e_q, e_d;

    logic [15:0] mem [DEPTH];
    logic [15:0] mem_rdata;
    logic [15:0] bus;
    logic [15:0] alu_res;
    logic        alu_carry;
    logic [16:0] sum;

    assign mem_rdata = mem[ar_q];

    always_comb begin
        bus = '0;
        case (bus_ctrl)
            3'd0: bus = '0;
            3'd1: bus = {{(16-AW){1'b0}}, ar_q};
            3'd2: bus = {{(16-AW){1'b0}}, pc_q};
            3'd3: bus = dr_q;
            3'd4: bus = ac_q;
            3'd5: bus = ir_q;
            3'd6: bus = tr_q;
            3'd7: bus = mem_rd ? mem_rdata : '0;
            default: bus = '0;
        endcase
    end

    // ALU operand is the DR register itself, never the bus
    always_comb begin
        sum       = {1'b0, ac_q} + {1'b0, dr_q};
        alu_res   = ac_q;
        alu_carry = sum[16];
        case (ir_q[14:12])
            3'd0: alu_res = ac_q & dr_q;
            3'd1: alu_res = sum[15:0];
            3'd2: alu_res = dr_q;
            3'd3: alu_res = ac_q | dr_q;
            3'd4: alu_res = dr_q;
            3'd5: alu_res = ac_q;
            3'd6: alu_res = ac_q ^ dr_q;
            3'd7: alu_res = ac_q;
            default: alu_res = ac_q;
        endcase
    end

    always_comb begin
        ar_d = ar_q;
        pc_d = pc_q;
        dr_d = dr_q;
        ac_d = ac_q;
        ir_d = ir_q;
        tr_d = tr_q;
        e_d  = e_q;

        if (ar_clr)      ar_d = '0;
        else if (ar_ld)  ar_d = bus[AW-1:0];
        else if (ar_inc) ar_d = ar_q + AW'(1);

        if (pc_clr)      pc_d = '0;
        else if (pc_ld)  pc_d = bus[AW-1:0];
        else if (pc_inc) pc_d = pc_q + AW'(1);

        if (dr_clr)      dr_d = '0;
        else if (dr_ld)  dr_d = bus;
        else if (dr_inc) dr_d = dr_q + 16'd1;

        // E only moves with an effective AC load of the add operation
        if (ac_clr) begin
            ac_d = '0;
        end else if (ac_ld) begin
            ac_d = alu_res;
            if (ir_q[14:12] == 3'd1) e_d = alu_carry;
        end else if (ac_inc) begin
            ac_d = ac_q + 16'd1;
        end

        if (ir_ld) ir_d = bus;

        if (tr_clr)      tr_d = '0;
        else if (tr_ld)  tr_d = bus;
        else if (tr_inc) tr_d = tr_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
            e_q  <= 1'b0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
            e_q  <= e_d;
        end
    end

    // Program-load write comes last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (mem_wr)  mem[ar_q]      <= bus;
            if (prog_we) mem[prog_addr] <= prog_data;
        end
    end

    assign instruction = ir_q[15:12];
    assign ac_out      = ac_q;
    assign pc_out      = pc_q;
    assign e_out       = e_q;

endmodule

// File: tb/tb_basic_datapath.sv
// Self-checking bench for basic_datapath: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_basic_datapath;

    localparam int AW = 12;

    localparam logic [23:0] AR_LD  = 24'h000008;
    localparam logic [23:0] AR_INC = 24'h000010;
    localparam logic [23:0] PC_LD  = 24'h000040;
    localparam logic [23:0] PC_INC = 24'h000080;
    localparam logic [23:0] PC_CLR = 24'h000100;
    localparam logic [23:0] DR_LD  = 24'h000200;
    localparam logic [23:0] AC_LD  = 24'h001000;
    localparam logic [23:0] AC_INC = 24'h002000;
    localparam logic [23:0] IR_LD  = 24'h008000;
    localparam logic [23:0] TR_LD  = 24'h040000;
    localparam logic [23:0] TR_CLR = 24'h100000;
    localparam logic [23:0] MEM_RD = 24'h200000;
    localparam logic [23:0] MEM_WR = 24'h400000;

    logic          clk;
    logic          rst_n;
    logic [23:0]   reg_mem_ctrl;
    logic [2:0]    bus_ctrl;
    logic [3:0]    instruction;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [15:0]   ac_out;
    logic [AW-1:0] pc_out;
    logic          e_out;

    int numChecks = 0;
    int numFails  = 0;

    int mAr, mPc, mDr, mAc, mIr, mTr, mE;
    logic [15:0] mMem [4096];

    typedef struct {
        logic [23:0] ctrl;
        logic [2:0]  bsel;
        logic [15:0] expAc;
        logic [15:0] expPc;
        logic        expE;
        logic [3:0]  expIns;
    } vec_t;

    vec_t vecs [13];

    basic_datapath #(.AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_mem_ctrl (reg_mem_ctrl),
        .bus_ctrl     (bus_ctrl),
        .instruction  (instruction),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .ac_out       (ac_out),
        .pc_out       (pc_out),
        .e_out        (e_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nextVal(int cur, logic clr, logic ld, logic inc, int loadVal, int modulus);
        if (clr) return 0;
        if (ld)  return loadVal % modulus;
        if (inc) return (cur + 1) % modulus;
        return cur;
    endfunction

    function automatic void modelReset();
        mAr = 0; mPc = 0; mDr = 0; mAc = 0; mIr = 0; mTr = 0; mE = 0;
    endfunction

    // One clock of architectural behaviour, all from pre-edge values
    function automatic void modelStep(logic [23:0] ctrl, logic [2:0] bsel, logic pwe,
                                      logic [11:0] paddr, logic [15:0] pdata);
        int src [8];
        int bus, op, aluv;
        src[0] = 0;
        src[1] = mAr;
        src[2] = mPc;
        src[3] = mDr;
        src[4] = mAc;
        src[5] = mIr;
        src[6] = mTr;
        src[7] = ctrl[21] ? int'(mMem[mAr]) : 0;
        bus = src[bsel];
        op  = (mIr / 4096) % 8;
        case (op)
            0: aluv = mAc & mDr;
            1: aluv = (mAc + mDr) % 65536;
            2: aluv = mDr;
            3: aluv = mAc | mDr;
            4: aluv = mDr;
            6: aluv = mAc ^ mDr;
            default: aluv = mAc;
        endcase
        if (ctrl[22]) mMem[mAr] = 16'(bus);
        if (pwe) mMem[paddr] = pdata;
        if (ctrl[12] && !ctrl[14] && op == 1) mE = (mAc + mDr > 65535) ? 1 : 0;
        mAr = nextVal(mAr, ctrl[5],  ctrl[3],  ctrl[4],  bus,  4096);
        mPc = nextVal(mPc, ctrl[8],  ctrl[6],  ctrl[7],  bus,  4096);
        mDr = nextVal(mDr, ctrl[11], ctrl[9],  ctrl[10], bus,  65536);
        mAc = nextVal(mAc, ctrl[14], ctrl[12], ctrl[13], aluv, 65536);
        mIr = nextVal(mIr, 1'b0,     ctrl[15], 1'b0,     bus,  65536);
        mTr = nextVal(mTr, ctrl[20], ctrl[18], ctrl[19], bus,  65536);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_ac",  ac_out,                  16'(mAc));
        checkOutput("model_pc",  {4'h0, pc_out},          16'(mPc));
        checkOutput("model_e",   {15'h0, e_out},          16'(mE));
        checkOutput("model_ins", {12'h000, instruction},  16'(mIr / 4096));
    endtask

    task automatic applyStimulus(input logic [23:0] ctrl, input logic [2:0] bsel, input logic pwe,
                                 input logic [11:0] paddr, input logic [15:0] pdata);
        @(negedge clk);
        reg_mem_ctrl = ctrl;
        bus_ctrl     = bsel;
        prog_we      = pwe;
        prog_addr    = paddr;
        prog_data    = pdata;
        @(posedge clk);
        if (rst_n) modelStep(ctrl, bsel, pwe, paddr, pdata);
        #1;
        checkModel();
    endtask

    task automatic idleInputs();
        reg_mem_ctrl = '0;
        bus_ctrl     = '0;
        prog_we      = 1'b0;
        prog_addr    = '0;
        prog_data    = '0;
    endtask

    task automatic asyncReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "_ac"},  ac_out,                 16'h0000);
        checkOutput({tag, "_pc"},  {4'h0, pc_out},         16'h0000);
        checkOutput({tag, "_e"},   {15'h0, e_out},         16'h0000);
        checkOutput({tag, "_ins"}, {12'h000, instruction}, 16'h0000);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;
    endtask

    task automatic progWrite(input logic [11:0] addr, input logic [15:0] data);
        applyStimulus(24'h0, 3'd0, 1'b1, addr, data);
    endtask

    initial begin
        vecs[0]  = '{PC_INC,                 3'd0, 16'h0000, 16'h0001, 1'b0, 4'h0};
        vecs[1]  = '{PC_INC,                 3'd0, 16'h0000, 16'h0002, 1'b0, 4'h0};
        vecs[2]  = '{PC_INC,                 3'd0, 16'h0000, 16'h0003, 1'b0, 4'h0};
        vecs[3]  = '{AR_LD,                  3'd2, 16'h0000, 16'h0003, 1'b0, 4'h0};
        vecs[4]  = '{MEM_RD | IR_LD | AR_INC, 3'd7, 16'h0000, 16'h0003, 1'b0, 4'h2};
        vecs[5]  = '{MEM_RD | DR_LD,         3'd7, 16'h0000, 16'h0003, 1'b0, 4'h2};
        vecs[6]  = '{AC_LD,                  3'd0, 16'hFFFF, 16'h0003, 1'b0, 4'h2};
        vecs[7]  = '{PC_CLR,                 3'd0, 16'hFFFF, 16'h0000, 1'b0, 4'h2};
        vecs[8]  = '{AR_LD,                  3'd2, 16'hFFFF, 16'h0000, 1'b0, 4'h2};
        vecs[9]  = '{MEM_RD | IR_LD | PC_INC, 3'd7, 16'hFFFF, 16'h0001, 1'b0, 4'h1};
        vecs[10] = '{AR_LD,                  3'd5, 16'hFFFF, 16'h0001, 1'b0, 4'h1};
        vecs[11] = '{MEM_RD | DR_LD,         3'd7, 16'hFFFF, 16'h0001, 1'b0, 4'h1};
        vecs[12] = '{AC_LD,                  3'd0, 16'h0001, 16'h0001, 1'b1, 4'h1};

        rst_n = 1'b0;
        idleInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkModel();
        releaseReset();

        $display("[TB] preloading memory");
        for (int a = 0; a < 4096; a++) progWrite(12'(a), 16'($urandom));
        progWrite(12'h000, 16'h1234);
        progWrite(12'h001, 16'hA007);
        progWrite(12'h003, 16'h2004);
        progWrite(12'h004, 16'hFFFF);
        progWrite(12'h005, 16'h0002);
        progWrite(12'h007, 16'h0009);
        progWrite(12'h009, 16'hBEEF);

        $display("[TB] reset behaviour");
        repeat (3) applyStimulus(PC_INC | AC_INC, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("pre_reset_pc", {4'h0, pc_out}, 16'h0003);
        asyncReset("async_rst");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(24'($urandom), 3'($urandom), 1'($urandom), 12'($urandom), 16'($urandom));
            checkOutput("rst_hold_ac", ac_out, 16'h0000);
            checkOutput("rst_hold_pc", {4'h0, pc_out}, 16'h0000);
            checkOutput("rst_hold_ins", {12'h000, instruction}, 16'h0000);
        end
        releaseReset();
        applyStimulus(MEM_RD | PC_LD | IR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        checkOutput("mem_kept_pc", {4'h0, pc_out}, 16'h0234);
        checkOutput("mem_kept_ins", {12'h000, instruction}, 16'h0001);
        asyncReset("rst2");
        releaseReset();
        progWrite(12'h000, 16'h1005);

        $display("[TB] fetch and direct ADD vectors");
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].ctrl, vecs[v].bsel, 1'b0, 12'h0, 16'h0);
            checkOutput($sformatf("vec%0d_ac", v),  ac_out,                 vecs[v].expAc);
            checkOutput($sformatf("vec%0d_pc", v),  {4'h0, pc_out},         vecs[v].expPc);
            checkOutput($sformatf("vec%0d_e", v),   {15'h0, e_out},         {15'h0, vecs[v].expE});
            checkOutput($sformatf("vec%0d_ins", v), {12'h000, instruction}, {12'h000, vecs[v].expIns});
        end

        $display("[TB] indirect LDA");
        applyStimulus(AR_LD, 3'd2, 1'b0, 12'h0, 16'h0);
        applyStimulus(MEM_RD | IR_LD | PC_INC, 3'd7, 1'b0, 12'h0, 16'h0);
        checkOutput("ind_ins", {12'h000, instruction}, 16'h000A);
        checkOutput("ind_pc", {4'h0, pc_out}, 16'h0002);
        applyStimulus(AR_LD, 3'd5, 1'b0, 12'h0, 16'h0);
        applyStimulus(MEM_RD | AR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        applyStimulus(MEM_RD | DR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        applyStimulus(AC_LD, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("ind_ac", ac_out, 16'hBEEF);
        checkOutput("ind_e_kept", {15'h0, e_out}, 16'h0001);
        applyStimulus(PC_LD, 3'd1, 1'b0, 12'h0, 16'h0);
        checkOutput("ind_ar", {4'h0, pc_out}, 16'h0009);

        $display("[TB] store and program-load conflict");
        progWrite(12'h009, 16'h55AA);
        applyStimulus(MEM_RD | DR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        applyStimulus(AC_LD, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("sta_ac", ac_out, 16'h55AA);
        progWrite(12'h009, 16'h0010);
        applyStimulus(MEM_RD | AR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        applyStimulus(MEM_WR, 3'd4, 1'b0, 12'h0, 16'h0);
        applyStimulus(MEM_RD | PC_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        checkOutput("sta_mem", {4'h0, pc_out}, 16'h05AA);
        applyStimulus(MEM_WR, 3'd4, 1'b1, 12'h010, 16'h1111);
        applyStimulus(MEM_RD | PC_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        checkOutput("conflict_mem", {4'h0, pc_out}, 16'h0111);
        applyStimulus(MEM_RD | DR_LD, 3'd7, 1'b1, 12'h010, 16'h3333);
        applyStimulus(AC_LD, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("old_data_read", ac_out, 16'h1111);
        applyStimulus(MEM_RD | PC_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        checkOutput("new_data_read", {4'h0, pc_out}, 16'h0333);

        $display("[TB] wrap, priority and simultaneous sampling");
        progWrite(12'h010, 16'h0FFF);
        applyStimulus(MEM_RD | PC_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        checkOutput("pc_max", {4'h0, pc_out}, 16'h0FFF);
        applyStimulus(PC_INC, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("pc_wrap", {4'h0, pc_out}, 16'h0000);
        applyStimulus(MEM_RD | TR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        applyStimulus(DR_LD, 3'd6, 1'b0, 12'h0, 16'h0);
        applyStimulus(AC_LD, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("tr_loaded", ac_out, 16'h0FFF);
        applyStimulus(MEM_RD | TR_CLR | TR_LD, 3'd7, 1'b0, 12'h0, 16'h0);
        applyStimulus(DR_LD, 3'd6, 1'b0, 12'h0, 16'h0);
        applyStimulus(AC_LD, 3'd0, 1'b0, 12'h0, 16'h0);
        checkOutput("tr_clr_wins", ac_out, 16'h0000);
        applyStimulus(AR_LD | AR_INC, 3'd1, 1'b0, 12'h0, 16'h0);
        applyStimulus(PC_LD, 3'd1, 1'b0, 12'h0, 16'h0);
        checkOutput("ar_ld_beats_inc", {4'h0, pc_out}, 16'h0010);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] pa;
            pa = ($urandom_range(3) == 0) ? 12'(mAr) : 12'($urandom);
            applyStimulus(24'($urandom), 3'($urandom_range(7)), ($urandom_range(7) == 0),
                          pa, 16'($urandom));
            if (i % 700 == 350) begin
                asyncReset("rand_rst");
                releaseReset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/basic_datapath.md
# basic_datapath

Register/memory datapath for the accumulator CPU. It executes the 24-bit register/memory control word and the 3-bit bus select issued each cycle by `control_unit`, and returns the instruction opcode field to it. The block holds AR, PC, DR, AC, IR, TR, the E carry flag, a shared 16-bit bus, the ALU and a single-port word memory with a program-load port.

## Interface
- `AW`, default 12: address width; memory depth is 2^AW words; legal range 4..12.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `reg_mem_ctrl`  in  24: control word. Bit 3/4/5 is AR load/inc/clr. Bit 6/7/8 is PC load/inc/clr. Bit 9/10/11 is DR load/inc/clr. Bit 12/13/14 is AC load/inc/clr. Bit 15 is IR load. Bit 18/19/20 is TR load/inc/clr. Bit 21 is mem read. Bit 22 is mem write. Bits 0-2, 16, 17 and 23 are ignored.
- `bus_ctrl`  in  3: bus source. 0 is zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- `instruction`  out  4: IR[15:12]. Bit 3 is the indirect flag; bits 2:0 are the opcode.
- `prog_we`  in  1: program-load write strobe.
- `prog_addr`  in  AW: program-load address.
- `prog_data`  in  16: program-load data.
- `ac_out`  out  16: AC.
- `pc_out`  out  AW: PC.
- `e_out`  out  1: E flag.

## Operation
- Register widths:
  - AR and PC are AW bits.
  - DR, AC, IR, TR and the bus are 16 bits.
- Bus (combinational):
  - AR and PC sources are zero-extended.
  - Source 7 drives `mem[AR]` when bit 21 is set, else 0.
- Per-register priority: clr > load > inc.
  - Load takes the bus; AR and PC take bus[AW-1:0].
  - Increment wraps modulo 2^width.
- AC load writes the ALU result, selected by IR[14:12] with operand DR (the register, not the bus):
  - 0: AC&DR.
  - 1: AC+DR, with carry-out to E.
  - 2: DR.
  - 3: AC|DR.
  - 4: DR.
  - 5: AC (hold).
  - 6: AC^DR.
  - 7: AC (hold).
- E changes only on an AC load with op 1. It is unaffected by AC inc/clr.
- Memory:
  - Read is combinational from `mem[AR]`.
  - Bit 22 writes the bus value to `mem[AR]` on the edge.
  - `prog_we` writes `prog_data` to `mem[prog_addr]` on the edge.
  - If both write the same address in one cycle, `prog_we` wins. If the addresses differ, both writes occur.
  - A same-cycle read and write of the same address returns the old data on the bus.
- Register sampling: all register updates in one cycle sample the pre-edge bus and register values. This allows swaps such as AR<-IR in the same cycle that IR is being read.
- Memory reset: the memory array is not reset; contents are undefined until written.
- Expected sequence from `control_unit` (this is the verification reference, not enforced):
  - t0: AR<-PC.
  - t1: IR<-M, PC++.
  - t2: AR<-IR.
  - t3 (indirect only): AR<-M.
  - t4: DR<-M, or M<-AC for op 5.
  - t5: AC<-ALU.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - AR, PC, DR, AC, IR, TR and E all go to 0.
  - Therefore `instruction`=0, `ac_out`=0, `pc_out`=0, `e_out`=0.
  - Memory is untouched.
  - Reset deassertion takes effect at the next rising edge. No edge-synchronous update occurs while `rst_n`=0.
- Register latency: 1 cycle from a control bit to the visible register value. `instruction` follows IR in the same cycle it updates.
- Bus-to-control path: combinational from `bus_ctrl`, AR and memory only. There is no combinational path from `reg_mem_ctrl` to outputs.
- Reset mid-instruction: all registers clear immediately. The memory write of the current cycle is suppressed if reset is low at the edge.
- Undefined control encodings (e.g. load+inc on one register) resolve only by the priority rule above. No error flag is raised.

## Test plan
- Reset check:
  - Stimulus: hold `rst_n`=0 with random controls.
  - Required response: all outputs stay 0. A memory word preloaded with 0x1234 still reads 0x1234 after reset.
- Fetch:
  - Stimulus: mem[0]=0x1005; run t0 (bus 2, AR ld), then t1 (bus 7, rd, IR ld, PC inc).
  - Required response: IR=0x1005, `instruction`=4'h1, PC=1.
- Direct ADD with carry:
  - Stimulus: AC=0xFFFF, mem[5]=0x0002; run t2 (bus 5, AR ld), t4 (bus 7, rd, DR ld), t5 (AC ld, IR=0x1005).
  - Required response: AC=0x0001, E=1.
- Indirect LDA:
  - Stimulus: IR=0xA007, mem[7]=0x0009, mem[9]=0xBEEF; run t2, t3 (bus 7, rd, AR ld), t4, t5.
  - Required response: AR=9, AC=0xBEEF, E unchanged.
- STA plus program-load conflict:
  - Stimulus: AC=0x55AA, AR=0x010; assert bus 4 + write. Next cycle, the same write together with `prog_we` to 0x010 with 0x1111.
  - Required response: mem[0x010]=0x55AA after the first cycle, then 0x1111.
- Wrap, priority and simultaneous sampling:
  - Stimulus: PC=0xFFF with PC inc; then TR clr+ld together; then AR ld from bus 1 with AR inc.
  - Required response: PC=0x000; TR=0; AR takes the pre-edge AR value (load beats inc).
